instruction_fetch_buffer: RTL and testbench
===========================================

# instruction_fetch_buffer

Fetch stage sitting directly upstream of the decode/control path: generates word-aligned fetch addresses, reads the byte-addressed instruction memory over a request/ready handshake, and queues up to DEPTH fetched instructions with their PCs in a show-ahead FIFO. The consumer (control unit / register-file read) takes instructions with a valid/accept handshake. A branch redirect from execute flushes the queue, drops any in-flight response, and restarts fetch at the target.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- imemAddress  out  32  fetch byte address; equals fetch PC; bits [1:0] always 0
- imemRequest  out  1  fetch request to instruction memory
- imemReady  in  1  memory response; imemData valid in the same cycle
- imemData  in  32  fetched instruction word
- instrValid  out  1  head entry valid
- instruction  out  32  head instruction
- instrPC  out  32  PC of head instruction
- instrAccept  in  1  consumer takes head this cycle (ignored when instrValid=0)
- redirectValid  in  1  branch taken; flush and refetch
- redirectTarget  in  32  new fetch PC; bits [1:0] forced to 0
- bufferCount  out  clog2(DEPTH)+1  entries currently queued

## Operation
- State machine IDLE, REQ, DROP. imemRequest = (state==REQ or DROP).
- Fetch PC register; at most one outstanding request.
- Handshake: while imemRequest=1, imemAddress must not change until the cycle imemReady=1. Request completes on the edge where imemRequest=1 and imemReady=1.
- IDLE: if count<DEPTH -> REQ.
- REQ, imemReady=1, no redirect: push {fetchPC, imemData}; fetchPC += 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0); stay REQ if next count <DEPTH else IDLE.
- REQ, imemReady=0, no redirect: hold.
- REQ, redirect with imemReady=1: discard response, no push; fetchPC <= target; -> REQ.
- REQ, redirect with imemReady=0: fetchPC <= target; -> DROP (address output keeps old value until response; hold old address in a separate register).
- DROP: keep request with old address; on imemReady discard data -> REQ at target. A second redirect in DROP overwrites the pending target.
- IDLE, redirect: fetchPC <= target; -> REQ.
- Redirect: queue cleared on that edge; a same-cycle instrAccept counts as taken (consumer owns that instruction); no push that cycle.
- Next count = count + push − pop; push and pop in the same cycle allowed, including at full (push cannot occur at full since request only issues below DEPTH, except when a pop is simultaneous — next-state rule above uses next count).
- Show-ahead: instruction/instrPC are head entry combinationally; instrValid = (count!=0).

## Timing
- Reset (reset=0 at edge): state IDLE, fetchPC=RESET_PC, count 0, queue pointers 0. Outputs: imemRequest 0, imemAddress RESET_PC, instrValid 0, bufferCount 0; instruction/instrPC don't-care while instrValid=0.
- Reset mid-request abandons it; imemRequest 0 the cycle after; memory is reset by the same reset.
- Startup: first edge with reset=1 -> REQ; with zero-wait memory first push next edge; instrValid high 2 edges after reset release.
- Steady state, zero-wait memory, consumer always accepting: one instruction per cycle.
- Redirect latency: redirect sampled at edge E (not in DROP-pending response): request to target visible after E; target instruction valid after E+1 with zero-wait memory. instrValid=0 for the cycle after E.
- Stale data never enters the queue after a redirect.

## Test plan
- Zero-wait memory holding words at 0x0,0x4,0x8,0xC; instrAccept=1 -> after reset release, instrValid at edge 2, instrPC 0x0,0x4,0x8,0xC on consecutive cycles, correct words.
- instrAccept=0 -> bufferCount reaches 4, imemRequest drops, imemAddress 0x10, instrPC stays 0x0; pulse instrAccept one cycle -> one fetch of 0x10, bufferCount back to 4, head 0x4.
- Memory with 3-cycle latency -> imemAddress stable for all 3 request cycles, exactly one push per response, bufferCount increments by 1.
- Redirect to 0x40 while request for 0x8 outstanding, imemReady low -> DROP, address stays 0x8 until ready, response discarded, next request 0x40, first valid instrPC 0x40, no 0x8 entry.
- Redirect to 0x40 in same cycle as imemReady and instrAccept -> accepted head consumed, response dropped, bufferCount 0 next cycle, next head instrPC 0x40.
- reset=0 while imemRequest=1 with 2 entries queued -> next cycle imemRequest 0, bufferCount 0, instrValid 0, imemAddress RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_buffer.sv
// rtl/instruction_fetch_buffer.sv - fetch address generator, imem handshake and show-ahead instruction queue
module instruction_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imemAddress,
    output logic                     imemRequest,
    input  logic                     imemReady,
    input  logic [31:0]              imemData,
    output logic                     instrValid,
    output logic [31:0]              instruction,
    output logic [31:0]              instrPC,
    input  logic                     instrAccept,
    input  logic                     redirectValid,
    input  logic [31:0]              redirectTarget,
    output logic [$clog2(DEPTH):0]   bufferCount
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0] START_PC = RESET_PC & ~32'h3;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   hold_addr_q, hold_addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_pc_q    [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];

    logic          push;
    logic          pop;
    logic [CW-1:0] count_next;
    logic [31:0]   target;

    assign target     = redirectTarget & ~32'h3;
    assign push       = (state_q == REQ) && imemReady && !redirectValid;
    assign pop        = (count_q != '0) && instrAccept;
    assign count_next = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= START_PC;
            hold_addr_q <= START_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            hold_addr_q <= hold_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
            fifo_instr_q[wr_ptr_q] <= imemData;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        hold_addr_d = hold_addr_q;
        case (state_q)
            IDLE: begin
                if (redirectValid) begin
                    fetch_pc_d = target;
                    state_d    = REQ;
                end else if (count_q < FULL) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirectValid) begin
                    fetch_pc_d = target;
                    // Response still owed for the old address: keep presenting it until it lands.
                    if (!imemReady) begin
                        hold_addr_d = fetch_pc_q;
                        state_d     = DROP;
                    end
                end else if (imemReady) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = (count_next < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (redirectValid) begin
                    fetch_pc_d = target;
                end
                if (imemReady) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d  = count_next;
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        if (redirectValid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_comb begin
        imemRequest = (state_q != IDLE);
        imemAddress = (state_q == DROP) ? hold_addr_q : fetch_pc_q;
        instrValid  = (count_q != '0);
        instruction = fifo_instr_q[rd_ptr_q];
        instrPC     = fifo_pc_q[rd_ptr_q];
        bufferCount = count_q;
    end
endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// tb/tb_instruction_fetch_buffer.sv - vector table, latency sequence and randomized scoreboard for instruction_fetch_buffer
module tb_instruction_fetch_buffer;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] imemAddress;
    logic        imemRequest;
    logic        imemReady;
    logic [31:0] imemData;
    logic        instrValid;
    logic [31:0] instruction;
    logic [31:0] instrPC;
    logic        instrAccept;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic [2:0]  bufferCount;

    instruction_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imemAddress    (imemAddress),
        .imemRequest    (imemRequest),
        .imemReady      (imemReady),
        .imemData       (imemData),
        .instrValid     (instrValid),
        .instruction    (instruction),
        .instrPC        (instrPC),
        .instrAccept    (instrAccept),
        .redirectValid  (redirectValid),
        .redirectTarget (redirectTarget),
        .bufferCount    (bufferCount)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imemData = word_at(imemAddress);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        acc;
        logic        redir;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic v(input logic r, input logic rdy, input logic acc, input logic redir,
                     input logic [31:0] tgt, input logic req, input logic [31:0] addr,
                     input logic val, input logic [31:0] pc, input int cnt);
        vec_t x;
        x.rst_n = r; x.rdy = rdy; x.acc = acc; x.redir = redir; x.tgt = tgt;
        x.e_req = req; x.e_addr = addr; x.e_valid = val; x.e_pc = pc; x.e_cnt = 3'(cnt);
        vecs.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rst_row();
        v(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    int          lat;
    int          accepted;
    logic [31:0] exp_pc;
    logic        prev_pending;
    logic [31:0] prev_addr;
    logic [31:0] tgt;

    initial begin
        reset = 0; imemReady = 0; instrAccept = 0; redirectValid = 0; redirectTarget = 0;

        // startup with zero-wait memory, consumer always accepting, then same-cycle redirect
        rst_row(); rst_row();
        v(1, 1, 1, 0, 0, 1, 32'h0,  0, 0,     0);
        v(1, 1, 1, 0, 0, 1, 32'h4,  1, 32'h0, 1);
        v(1, 1, 1, 0, 0, 1, 32'h8,  1, 32'h4, 1);
        v(1, 1, 1, 0, 0, 1, 32'hC,  1, 32'h8, 1);
        v(1, 1, 1, 0, 0, 1, 32'h10, 1, 32'hC, 1);
        v(1, 1, 1, 1, 32'h41, 1, 32'h40, 0, 0, 0);
        v(1, 1, 1, 0, 0, 1, 32'h44, 1, 32'h40, 1);
        // fill to DEPTH with no consumer, then a single accept pulse
        rst_row();
        v(1, 1, 0, 0, 0, 1, 32'h0,  0, 0,     0);
        v(1, 1, 0, 0, 0, 1, 32'h4,  1, 32'h0, 1);
        v(1, 1, 0, 0, 0, 1, 32'h8,  1, 32'h0, 2);
        v(1, 1, 0, 0, 0, 1, 32'hC,  1, 32'h0, 3);
        v(1, 1, 0, 0, 0, 0, 32'h10, 1, 32'h0, 4);
        v(1, 1, 0, 0, 0, 0, 32'h10, 1, 32'h0, 4);
        v(1, 1, 1, 0, 0, 0, 32'h10, 1, 32'h4, 3);
        v(1, 1, 0, 0, 0, 1, 32'h10, 1, 32'h4, 3);
        v(1, 1, 0, 0, 0, 0, 32'h14, 1, 32'h4, 4);
        // redirect while the 0x8 request is still waiting on memory
        rst_row();
        v(1, 1, 0, 0, 0, 1, 32'h0,  0, 0,     0);
        v(1, 1, 0, 0, 0, 1, 32'h4,  1, 32'h0, 1);
        v(1, 1, 0, 0, 0, 1, 32'h8,  1, 32'h0, 2);
        v(1, 0, 0, 1, 32'h40, 1, 32'h8, 0, 0, 0);
        v(1, 0, 0, 0, 0, 1, 32'h8,  0, 0,     0);
        v(1, 1, 0, 0, 0, 1, 32'h40, 0, 0,     0);
        v(1, 1, 0, 0, 0, 1, 32'h44, 1, 32'h40, 1);
        // reset with a request outstanding and two entries queued, then PC wrap
        rst_row();
        v(1, 1, 0, 0, 0, 1, 32'h0,  0, 0,     0);
        v(1, 1, 0, 0, 0, 1, 32'h4,  1, 32'h0, 1);
        v(1, 1, 0, 0, 0, 1, 32'h8,  1, 32'h0, 2);
        v(0, 1, 0, 0, 0, 0, 32'h0,  0, 0,     0);
        v(1, 1, 1, 1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 0, 0, 0);
        v(1, 1, 1, 0, 0, 1, 32'h0,  1, 32'hFFFF_FFFC, 1);
        v(1, 1, 1, 0, 0, 1, 32'h4,  1, 32'h0, 1);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst_n; imemReady = vecs[i].rdy; instrAccept = vecs[i].acc;
            redirectValid = vecs[i].redir; redirectTarget = vecs[i].tgt;
            step();
            chk($sformatf("row%0d imemRequest", i), 32'(imemRequest), 32'(vecs[i].e_req));
            chk($sformatf("row%0d imemAddress", i), imemAddress, vecs[i].e_addr);
            chk($sformatf("row%0d instrValid", i), 32'(instrValid), 32'(vecs[i].e_valid));
            chk($sformatf("row%0d bufferCount", i), 32'(bufferCount), 32'(vecs[i].e_cnt));
            if (vecs[i].e_valid) begin
                chk($sformatf("row%0d instrPC", i), instrPC, vecs[i].e_pc);
                chk($sformatf("row%0d instruction", i), instruction, word_at(vecs[i].e_pc));
            end
        end

        // 3-cycle memory latency: address held, single push on the response
        reset = 0; imemReady = 0; instrAccept = 0; redirectValid = 0; step();
        reset = 1; step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lat imemAddress", imemAddress, 32'h0);
            chk("lat imemRequest", 32'(imemRequest), 32'd1);
            chk("lat bufferCount", 32'(bufferCount), 32'd0);
        end
        imemReady = 1; step();
        chk("lat push count", 32'(bufferCount), 32'd1);
        chk("lat push pc", instrPC, 32'h0);
        chk("lat next addr", imemAddress, 32'h4);
        imemReady = 0; step();
        chk("lat no extra push", 32'(bufferCount), 32'd1);

        // randomized traffic against an in-order PC stream scoreboard
        reset = 0; imemReady = 0; instrAccept = 0; redirectValid = 0; step(); step();
        reset = 1;
        exp_pc = 32'h0; accepted = 0; lat = $urandom_range(0, 3);
        prev_pending = 1'b0; prev_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd addr align", 32'(imemAddress[1:0]), 32'd0);
            chk("rnd valid vs count", 32'(instrValid), 32'(bufferCount != 0));
            chk("rnd count bound", 32'(bufferCount <= DEPTH), 32'd1);
            if (prev_pending && imemRequest)
                chk("rnd addr stable", imemAddress, prev_addr);
            instrAccept   = ($urandom_range(0, 9) < 7);
            redirectValid = ($urandom_range(0, 24) == 0);
            tgt           = $urandom & 32'h0000_03FF;
            redirectTarget = tgt;
            if (imemRequest) begin
                if (lat == 0) begin
                    imemReady = 1'b1;
                    lat = $urandom_range(0, 3);
                end else begin
                    imemReady = 1'b0;
                    lat--;
                end
            end else begin
                imemReady = 1'b0;
            end
            if (instrValid && instrAccept) begin
                chk("rnd instrPC", instrPC, exp_pc);
                chk("rnd instruction", instruction, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
                accepted++;
            end
            if (redirectValid) exp_pc = tgt & ~32'h3;
            prev_pending = imemRequest && !imemReady;
            prev_addr    = imemAddress;
            step();
        end
        chk("rnd progress", 32'(accepted > 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
